nand_page_reader: RTL and testbench

Command sequencer that sits between the bus-side register wrapper and nand_master. It accepts a single page-read request (row/column address) and drives nand_master's activate/cmd_in/data_in/busy handshake. The sequence is: load the address bytes, issue the page-read command, then fetch PAGE_BYTES data bytes one at a time. Fetched bytes go into an internal FIFO, which the host drains through a valid/ready stream. This replaces per-byte bus polling of the status register.

---
 rtl/nand_page_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_nand_page_reader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_page_reader.sv
// Page-read sequencer in front of nand_master: loads the address bytes, issues
// READ_PAGE, fetches the page one GET_DATA at a time into a small FIFO and
// streams it out over a valid/ready interface.
module nand_page_reader #(
    parameter int unsigned ADDR_BYTES     = 5,
    parameter int unsigned PAGE_BYTES     = 2048,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter logic [7:0]  CMD_SET_ADDR   = 8'h05,
    parameter logic [7:0]  CMD_READ_PAGE  = 8'h0A,
    parameter logic [7:0]  CMD_GET_DATA   = 8'h0C,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic                    done,
    output logic                    error,
    output logic                    n_activate,
    output logic [7:0]              n_cmd_in,
    output logic [7:0]              n_data_in,
    input  logic [7:0]              n_data_out,
    input  logic                    n_busy
);

    localparam int unsigned IW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int unsigned PW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [IW-1:0] IdxLast     = IW'(ADDR_BYTES - 1);
    localparam logic [PW-1:0] PageLast    = PW'(PAGE_BYTES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FifoFull    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StAddrIssue,
        StAddrWait,
        StReadIssue,
        StReadWait,
        StFetchIssue,
        StFetchWait,
        StDrain
    } state_e;

    state_e                  state_q, state_d;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           page_cnt_q, page_cnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    settle_q, settle_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic [8:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           fifo_cnt_q;
    logic [8:0]              head;
    logic                    fifo_full, push, pop, flush;
    logic                    wait_st, wait_ok;

    assign fifo_full = (fifo_cnt_q == FifoFull);
    assign out_valid = (fifo_cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr_q];
    // Hide stale storage so outputs read zero while the FIFO is empty.
    assign out_data  = out_valid ? head[7:0] : 8'h00;
    assign out_last  = out_valid & head[8];
    assign req_ready = (state_q == StIdle);
    assign done      = done_q;
    assign error     = error_q;

    // Sequencer next state, activate strobe, FIFO push/flush and timeout.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        page_cnt_d = page_cnt_q;
        tcnt_d     = tcnt_q;
        settle_d   = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        n_activate = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        wait_st = (state_q == StAddrWait) || (state_q == StReadWait) ||
                  (state_q == StFetchWait);
        // The first wait cycle is skipped: nand_master raises busy one cycle late.
        wait_ok = wait_st && !settle_q && !n_busy;

        if (wait_st && !settle_q && n_busy) begin
            if (tcnt_q == TimeoutLast) begin
                error_d = 1'b1;
                flush   = 1'b1;
                state_d = StIdle;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    idx_d   = '0;
                    state_d = StAddrIssue;
                end
            end
            StAddrIssue: begin
                if (!n_busy) begin
                    n_activate = 1'b1;
                    state_d    = StAddrWait;
                end
            end
            StAddrWait: begin
                if (wait_ok) begin
                    if (idx_q == IdxLast) begin
                        state_d = StReadIssue;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StAddrIssue;
                    end
                end
            end
            StReadIssue: begin
                if (!n_busy) begin
                    n_activate = 1'b1;
                    state_d    = StReadWait;
                end
            end
            StReadWait: begin
                if (wait_ok) begin
                    page_cnt_d = '0;
                    state_d    = StFetchIssue;
                end
            end
            StFetchIssue: begin
                // Only one GET_DATA in flight and a free slot reserved for it.
                if (!n_busy && !fifo_full) begin
                    n_activate = 1'b1;
                    state_d    = StFetchWait;
                end
            end
            StFetchWait: begin
                if (wait_ok) begin
                    push = 1'b1;
                    if (page_cnt_q == PageLast) begin
                        state_d = StDrain;
                    end else begin
                        page_cnt_d = page_cnt_q + 1'b1;
                        state_d    = StFetchIssue;
                    end
                end
            end
            StDrain: begin
                if ((fifo_cnt_q == '0) || ((fifo_cnt_q == CW'(1)) && pop)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (n_activate) begin
            settle_d = 1'b1;
            tcnt_d   = '0;
        end
    end

    // Command and address byte are a function of the phase, so they hold from
    // the activate strobe until the matching wait completes.
    always_comb begin
        n_cmd_in  = 8'h00;
        n_data_in = 8'h00;
        unique case (state_q)
            StAddrIssue, StAddrWait: begin
                n_cmd_in  = CMD_SET_ADDR;
                n_data_in = addr_q[8*idx_q +: 8];
            end
            StReadIssue, StReadWait:   n_cmd_in = CMD_READ_PAGE;
            StFetchIssue, StFetchWait: n_cmd_in = CMD_GET_DATA;
            default: ;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            idx_q      <= '0;
            page_cnt_q <= '0;
            tcnt_q     <= '0;
            settle_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            page_cnt_q <= page_cnt_d;
            tcnt_q     <= tcnt_d;
            settle_q   <= settle_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // FIFO storage; entry bit 8 marks the final byte of the page.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {page_cnt_q == PageLast, n_data_out};
        end
    end

    // FIFO pointers and occupancy; a timeout discards everything queued.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_nand_page_reader.sv
// Bench for nand_page_reader: two instances (8-byte page with a 2-entry FIFO,
// and a 1-byte page), a behavioural nand_master with randomised busy time, a
// randomised consumer, and a reference of the expected command/data stream.
module tb_nand_page_reader;

    localparam int NAB    = 5;
    localparam int PAGE_A = 8;
    localparam int PAGE_B = 1;
    localparam int TMO    = 20;
    localparam logic [7:0] C_ADDR = 8'h05;
    localparam logic [7:0] C_READ = 8'h0A;
    localparam logic [7:0] C_GET  = 8'h0C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] nreset, req_valid, req_ready, out_valid, out_ready, out_last;
    logic [1:0] done, error, n_activate, n_busy;
    logic [1:0][39:0] req_addr;
    logic [1:0][7:0]  out_data, n_cmd_in, n_data_in, n_data_out;

    nand_page_reader #(
        .ADDR_BYTES(NAB), .PAGE_BYTES(PAGE_A), .FIFO_DEPTH(2), .CMD_SET_ADDR(C_ADDR),
        .CMD_READ_PAGE(C_READ), .CMD_GET_DATA(C_GET), .TIMEOUT_CYCLES(TMO)
    ) dut_a (
        .clk(clk), .nreset(nreset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0]), .done(done[0]), .error(error[0]),
        .n_activate(n_activate[0]), .n_cmd_in(n_cmd_in[0]), .n_data_in(n_data_in[0]),
        .n_data_out(n_data_out[0]), .n_busy(n_busy[0])
    );

    nand_page_reader #(
        .ADDR_BYTES(NAB), .PAGE_BYTES(PAGE_B), .FIFO_DEPTH(4), .CMD_SET_ADDR(C_ADDR),
        .CMD_READ_PAGE(C_READ), .CMD_GET_DATA(C_GET), .TIMEOUT_CYCLES(TMO)
    ) dut_b (
        .clk(clk), .nreset(nreset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1]), .done(done[1]), .error(error[1]),
        .n_activate(n_activate[1]), .n_cmd_in(n_cmd_in[1]), .n_data_in(n_data_in[1]),
        .n_data_out(n_data_out[1]), .n_busy(n_busy[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // nand_master model: busy rises one cycle after activate, then lasts a few cycles.
    int         busy_cnt [2] = '{0, 0};
    int         get_idx  [2] = '{0, 0};
    int         stuck_get[2] = '{-1, -1};
    logic [1:0] pend = '0, stuck = '0, force_busy = '0, stuck_read = '0;
    logic [7:0] page_data [2][16];
    int         busy_len = 3;
    bit         rand_busy = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pend[i] <= n_activate[i];
            if (n_activate[i]) begin
                if (n_cmd_in[i] == C_READ) begin
                    get_idx[i] <= 0;
                    if (stuck_read[i]) stuck[i] <= 1'b1;
                end
                if (n_cmd_in[i] == C_GET) begin
                    n_data_out[i] <= page_data[i][get_idx[i] % 16];
                    get_idx[i]    <= get_idx[i] + 1;
                    if (get_idx[i] == stuck_get[i]) stuck[i] <= 1'b1;
                end
            end
            if (pend[i]) busy_cnt[i] <= rand_busy ? int'($urandom_range(4, 1)) : busy_len;
            else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
            if (!stuck_read[i] && stuck_get[i] < 0) stuck[i] <= 1'b0;
        end
    end

    always_comb begin
        n_busy = '0;
        for (int i = 0; i < 2; i++) n_busy[i] = force_busy[i] | stuck[i] | (busy_cnt[i] != 0);
    end

    // Consumer: 0 = stalled, 1 = always ready, 2 = random.
    int rdy_mode [2] = '{1, 1};
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            case (rdy_mode[i])
                0:       out_ready[i] = 1'b0;
                1:       out_ready[i] = 1'b1;
                default: out_ready[i] = 1'($urandom);
            endcase
        end
    end

    // Monitor on the falling edge: logs activates, stream handshakes, pulses.
    logic [7:0] act_cmd [2][64];
    logic [7:0] act_dat [2][64];
    int         act_cyc [2][64];
    logic [7:0] rx_dat  [2][32];
    logic       rx_last [2][32];
    int act_n[2], rx_n[2], done_n[2], done_cyc[2], err_n[2], err_cyc[2], last_hs[2];
    int prot_bad[2];
    logic [1:0] prev_act = '0;
    logic [7:0] last_cmd [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (n_activate[i]) begin
                if (n_busy[i] || prev_act[i]) prot_bad[i]++;
                if (act_n[i] < 64) begin
                    act_cmd[i][act_n[i]] = n_cmd_in[i];
                    act_dat[i][act_n[i]] = n_data_in[i];
                    act_cyc[i][act_n[i]] = cyc;
                end
                act_n[i]++;
                last_cmd[i] = n_cmd_in[i];
            end else if (prev_act[i] && n_cmd_in[i] !== last_cmd[i]) begin
                prot_bad[i]++;
            end
            prev_act[i] = n_activate[i];
            if (out_valid[i] && out_ready[i]) begin
                if (rx_n[i] < 32) begin
                    rx_dat[i][rx_n[i]]  = out_data[i];
                    rx_last[i][rx_n[i]] = out_last[i];
                end
                rx_n[i]++;
                last_hs[i] = cyc;
            end
            if (done[i]) begin done_n[i]++; done_cyc[i] = cyc; end
            if (error[i]) begin err_n[i]++; err_cyc[i] = cyc; end
            if (done[i] && error[i]) prot_bad[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs(input int i);
        act_n[i] = 0; rx_n[i] = 0; done_n[i] = 0; err_n[i] = 0; prot_bad[i] = 0;
        done_cyc[i] = -1; err_cyc[i] = -1; last_hs[i] = -1;
        for (int k = 0; k < 16; k++) page_data[i][k] = 8'($urandom);
    endtask

    task automatic start_req(input int i, input logic [39:0] addr);
        clear_logs(i);
        @(posedge clk); #1;
        req_addr[i]  = addr;
        req_valid[i] = 1'b1;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_end(input int i, input int budget, input string tag);
        int n = 0;
        while (done_n[i] == 0 && err_n[i] == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 64'((done_n[i] + err_n[i]) != 0), 64'd1);
    endtask

    task automatic check_reset(input int i, input string tag);
        check({tag, "_req_ready"}, 64'(req_ready[i]), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid[i]), 64'd0);
        check({tag, "_out_data"}, 64'(out_data[i]), 64'd0);
        check({tag, "_out_last"}, 64'(out_last[i]), 64'd0);
        check({tag, "_done_err"}, 64'({done[i], error[i]}), 64'd0);
        check({tag, "_activate"}, 64'(n_activate[i]), 64'd0);
        check({tag, "_cmd_data"}, 64'({n_cmd_in[i], n_data_in[i]}), 64'd0);
    endtask

    // Reference: NAB x SET_ADDR (bytes low first), one READ_PAGE, page x GET_DATA;
    // the stream is the model's page bytes in order, last flag on the final byte,
    // and done exactly one cycle after the final handshake.
    task automatic verify_run(input int i, input logic [39:0] addr, input string tag);
        int npg = (i == 0) ? PAGE_A : PAGE_B;
        check({tag, "_act_count"}, 64'(act_n[i]), 64'(NAB + 1 + npg));
        for (int k = 0; k < NAB; k++) begin
            check({tag, "_addr_cmd"}, 64'(act_cmd[i][k]), 64'(C_ADDR));
            check({tag, "_addr_byte"}, 64'(act_dat[i][k]), 64'(8'(addr >> (8 * k))));
        end
        check({tag, "_read_cmd"}, 64'(act_cmd[i][NAB]), 64'(C_READ));
        for (int k = 0; k < npg; k++)
            check({tag, "_get_cmd"}, 64'(act_cmd[i][NAB + 1 + k]), 64'(C_GET));
        check({tag, "_rx_count"}, 64'(rx_n[i]), 64'(npg));
        for (int k = 0; k < npg; k++) begin
            check({tag, "_rx_data"}, 64'(rx_dat[i][k]), 64'(page_data[i][k]));
            check({tag, "_rx_last"}, 64'(rx_last[i][k]), 64'(k == npg - 1));
        end
        check({tag, "_done_n"}, 64'(done_n[i]), 64'd1);
        check({tag, "_err_n"}, 64'(err_n[i]), 64'd0);
        check({tag, "_done_time"}, 64'(done_cyc[i]), 64'(last_hs[i] + 1));
        check({tag, "_protocol"}, 64'(prot_bad[i]), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] addr;
        int n;
        nreset = '0; req_valid = '0; req_addr = '0;
        clear_logs(0); clear_logs(1);
        repeat (3) @(negedge clk);
        check_reset(0, "rst_a");
        check_reset(1, "rst_b");
        @(posedge clk); #1;
        nreset = 2'b11;

        // Fixed address, 3-cycle busy, req_valid held well into the transfer.
        addr = 40'h0403020100;
        clear_logs(0);
        @(posedge clk); #1;
        req_addr[0] = addr; req_valid[0] = 1'b1;
        n = 0;
        while (act_n[0] < NAB + 2 && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_end(0, 500, "basic");
        verify_run(0, addr, "basic");

        // Back-pressure: a 2-entry FIFO must cap GET_DATA at two until drained.
        rand_busy = 1'b1;
        rdy_mode[0] = 0;
        addr = {8'($urandom), $urandom};
        start_req(0, addr);
        repeat (200) @(negedge clk);
        check("bp_acts_stalled", 64'(act_n[0]), 64'(NAB + 1 + 2));
        check("bp_no_rx", 64'(rx_n[0]), 64'd0);
        check("bp_out_valid", 64'(out_valid[0]), 64'd1);
        rdy_mode[0] = 2;
        wait_end(0, 1000, "bp");
        verify_run(0, addr, "bp");

        for (int r = 0; r < 3; r++) begin
            addr = {8'($urandom), $urandom};
            start_req(0, addr);
            wait_end(0, 1000, "rand_a");
            verify_run(0, addr, "rand_a");
        end

        // Busy already high before the request: nothing may be issued.
        force_busy[0] = 1'b1;
        rdy_mode[0] = 1;
        addr = {8'($urandom), $urandom};
        start_req(0, addr);
        repeat (30) @(negedge clk);
        check("busy_pre_no_act", 64'(act_n[0]), 64'd0);
        check("busy_pre_not_idle", 64'(req_ready[0]), 64'd0);
        @(posedge clk); #1;
        force_busy[0] = 1'b0;
        wait_end(0, 500, "busy_pre");
        verify_run(0, addr, "busy_pre");

        // Busy stuck after READ_PAGE: error after settle cycle + TMO counting + register.
        stuck_read[0] = 1'b1;
        start_req(0, {8'($urandom), $urandom});
        wait_end(0, 500, "tmo_read");
        check("tmo_read_err_n", 64'(err_n[0]), 64'd1);
        check("tmo_read_done_n", 64'(done_n[0]), 64'd0);
        check("tmo_read_acts", 64'(act_n[0]), 64'(NAB + 1));
        check("tmo_read_time", 64'(err_cyc[0]), 64'(act_cyc[0][NAB] + TMO + 2));
        @(negedge clk);
        check("tmo_read_ready", 64'(req_ready[0]), 64'd1);
        check("tmo_read_single", 64'(error[0]), 64'd0);
        stuck_read[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("tmo_read_no_done", 64'(done_n[0]), 64'd0);

        // Timeout on the second GET_DATA with one byte queued: FIFO is flushed.
        stuck_get[0] = 1;
        rdy_mode[0] = 0;
        start_req(0, {8'($urandom), $urandom});
        wait_end(0, 500, "tmo_get");
        check("tmo_get_err_n", 64'(err_n[0]), 64'd1);
        check("tmo_get_acts", 64'(act_n[0]), 64'(NAB + 1 + 2));
        @(negedge clk);
        check("tmo_get_flushed", 64'(out_valid[0]), 64'd0);
        check("tmo_get_no_rx", 64'(rx_n[0]), 64'd0);
        stuck_get[0] = -1;
        repeat (10) @(negedge clk);

        // Reset in FETCH_WAIT with one byte queued, then a clean full request.
        start_req(0, {8'($urandom), $urandom});
        n = 0;
        while (act_n[0] < NAB + 3 && n < 500) begin @(negedge clk); n++; end
        check("rst_mid_reached", 64'(act_n[0]), 64'(NAB + 3));
        @(posedge clk); #1;
        check("rst_mid_pre_valid", 64'(out_valid[0]), 64'd1);
        nreset[0] = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_mid_activate", 64'(n_activate[0]), 64'd0);
        check("rst_mid_req_ready", 64'(req_ready[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        nreset[0] = 1'b1;
        rdy_mode[0] = 1;
        addr = {8'($urandom), $urandom};
        start_req(0, addr);
        wait_end(0, 1000, "after_rst");
        verify_run(0, addr, "after_rst");

        // Single-byte page.
        for (int r = 0; r < 2; r++) begin
            rdy_mode[1] = (r == 0) ? 1 : 2;
            addr = {8'($urandom), $urandom};
            start_req(1, addr);
            wait_end(1, 500, "page1");
            verify_run(1, addr, "page1");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
